// File: rtl/crc_frame_tx_pkg.sv
// Shared types and defaults for the CRC-32 transmit framer.
package crc_frame_tx_pkg;

  localparam int unsigned DefDataBits = 64;
  localparam int unsigned DefCrcBits  = 32;
  localparam logic [31:0] DefFinalXor = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StPass,
    StTrailer
  } state_e;

endpackage

// File: rtl/crc_frame_out_reg.sv
// Single-entry output register: loads when free, holds data while stalled.
module crc_frame_out_reg #(
  parameter int unsigned DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_last,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  output logic                 free
);

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      valid_q <= 1'b1;
      last_q  <= load_last;
    end else if (m_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign free    = !valid_q || m_ready;
  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;

endmodule

// File: rtl/crc_frame_tx.sv
// Transmit framer: forwards payload words, feeds the external CRC engine and
// appends a trailer word carrying the final FCS.
module crc_frame_tx
  import crc_frame_tx_pkg::*;
#(
  parameter int unsigned          DATA_BITS = DefDataBits,
  parameter int unsigned          CRC_BITS  = DefCrcBits,
  parameter int unsigned          MAX_WORDS = 256,
  parameter logic [CRC_BITS-1:0]  FINAL_XOR = DefFinalXor,
  parameter int unsigned          CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 crc_clr,
  output logic [DATA_BITS-1:0] crc_data,
  output logic                 crc_data_valid,
  input  logic [CRC_BITS-1:0]  crc_in,
  output logic [CNT_BITS-1:0]  frame_cnt,
  output logic                 err_len
);

  localparam int unsigned      WcBits  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [WcBits-1:0] LastIdx = WcBits'(MAX_WORDS - 1);

  state_e               state_q;
  logic [WcBits-1:0]    wcnt_q;
  logic                 err_len_q;
  logic [CNT_BITS-1:0]  frame_cnt_q;

  logic                 free;
  logic                 accept;
  logic                 trailer_load;
  logic [DATA_BITS-1:0] trailer_word;
  logic [DATA_BITS-1:0] load_data;

  always_comb begin
    accept       = (state_q == StPass) && s_valid && free;
    trailer_load = (state_q == StTrailer) && free;
    trailer_word = '0;
    trailer_word[CRC_BITS-1:0] = crc_in ^ FINAL_XOR;
    load_data    = trailer_load ? trailer_word : s_data;
  end

  assign s_ready        = (state_q == StPass) && free;
  assign crc_clr        = (state_q == StClear);
  assign crc_data       = s_data;
  assign crc_data_valid = accept;
  assign frame_cnt      = frame_cnt_q;
  assign err_len        = err_len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      err_len_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_len_q <= 1'b0;
      if (m_valid && m_ready && m_last) frame_cnt_q <= frame_cnt_q + CNT_BITS'(1);
      case (state_q)
        // The waiting word is not consumed here; it is accepted in StPass.
        StIdle: if (s_valid) state_q <= StClear;
        StClear: begin
          wcnt_q  <= '0;
          state_q <= StPass;
        end
        StPass: begin
          if (accept) begin
            wcnt_q <= wcnt_q + WcBits'(1);
            if (s_last || wcnt_q == LastIdx) begin
              state_q   <= StTrailer;
              err_len_q <= !s_last;
            end
          end
        end
        StTrailer: if (free) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  crc_frame_out_reg #(
    .DATA_BITS (DATA_BITS)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept || trailer_load),
    .load_data (load_data),
    .load_last (trailer_load),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .free      (free)
  );

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx with a stub CRC-32 engine and a frame-level model.
module tb_crc_frame_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;
  localparam int unsigned MAXW = 4;
  localparam int unsigned CNTB = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready = 1'b1;
  logic            crc_clr;
  logic [DW-1:0]   crc_data;
  logic            crc_data_valid;
  logic [CW-1:0]   crc_in;
  logic [CNTB-1:0] frame_cnt;
  logic            err_len;

  always #5 clk = ~clk;

  crc_frame_tx #(
    .DATA_BITS (DW),
    .CRC_BITS  (CW),
    .MAX_WORDS (MAXW),
    .FINAL_XOR (32'hFFFFFFFF),
    .CNT_BITS  (CNTB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .crc_clr        (crc_clr),
    .crc_data       (crc_data),
    .crc_data_valid (crc_data_valid),
    .crc_in         (crc_in),
    .frame_cnt      (frame_cnt),
    .err_len        (err_len)
  );

  // Reflected CRC-32 over one 64-bit word, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 64; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] eng;
  bit          const_crc = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) eng <= 32'hFFFFFFFF;
    else if (crc_clr) eng <= 32'hFFFFFFFF;
    else if (crc_data_valid) eng <= crc_step(eng, crc_data);
  end
  assign crc_in = const_crc ? 32'h12345678 : eng;

  logic [64:0] src_q[$], sent[$], exp_q[$], beats[$];
  logic [63:0] crc_words[$];
  int          beat_cyc[$], dv_cyc[$], clr_cyc[$];
  int          cyc = 0, err_n = 0, stall_viol = 0;
  bit          hold_v = 1'b0;
  logic [63:0] hold_d = '0;
  logic        hold_l = 1'b0;
  int          n_chk = 0, n_fail = 0;
  int          mr_mode = 0, base_beats = 0, exp_fc = 0, exp_err = 0, exp_nfr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      beats.push_back({m_last, m_data});
      beat_cyc.push_back(cyc);
    end
    if (crc_data_valid) begin
      dv_cyc.push_back(cyc);
      crc_words.push_back(crc_data);
    end
    if (crc_clr) clr_cyc.push_back(cyc);
    if (err_len) err_n <= err_n + 1;
    if (hold_v && !rst && (!m_valid || m_data !== hold_d || m_last !== hold_l))
      stall_viol <= stall_viol + 1;
    hold_v <= m_valid && !m_ready && !rst;
    hold_d <= m_data;
    hold_l <= m_last;
  end

  task automatic add_frame(input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      sent.push_back({with_last && (i == n - 1), $urandom(), $urandom()});
  endtask

  task automatic build_expected();
    logic [63:0] fr[$];
    logic [31:0] c;
    exp_q.delete();
    exp_err = 0;
    exp_nfr = 0;
    foreach (sent[i]) begin
      fr.push_back(sent[i][63:0]);
      exp_q.push_back({1'b0, sent[i][63:0]});
      if (sent[i][64] || fr.size() == MAXW) begin
        c = 32'hFFFFFFFF;
        foreach (fr[j]) c = crc_step(c, fr[j]);
        exp_q.push_back({1'b1, 32'h0, c ^ 32'hFFFFFFFF});
        if (!sent[i][64]) exp_err++;
        exp_nfr++;
        fr.delete();
      end
    end
  endtask

  // Drives src_q into the DUT until drained and the output is idle.
  task automatic pump(input int budget, input int stop_acc);
    int acc, k, rel, stall_left;
    bit done, hs;
    bit [7:0] stalled;
    acc = 0; done = 0; stall_left = 0; stalled = '0;
    for (k = 0; k < budget && !done; k++) begin
      if (src_q.size() > 0 && (mr_mode != 1 || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_data  = src_q[0][63:0];
        s_last  = src_q[0][64];
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
      end
      rel = beats.size() - base_beats;
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (mr_mode == 2 && m_valid && (rel == 1 || rel == 4) && rel < 8 && !stalled[rel]) begin
        m_ready = 1'b0;
        stall_left = 2;
        stalled[rel] = 1'b1;
      end else begin
        m_ready = (mr_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) begin
        void'(src_q.pop_front());
        acc++;
      end
      done = (src_q.size() == 0 && !hs && !m_valid) || (stop_acc >= 0 && acc == stop_acc);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL pump_timeout: got %0d accepts after %0d cycles, required drain", acc, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({m_valid, m_last, err_len, s_ready, crc_clr, crc_data_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {m_valid, m_last, err_len, s_ready, crc_clr, crc_data_valid});
    end
    n_chk++;
    if (m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_m_data: got %h required 0", m_data);
    end
    n_chk++;
    if (frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    int b0, c0, d0, cc, dc;
    logic [64:0] got;
    b0 = beats.size(); c0 = clr_cyc.size(); d0 = dv_cyc.size();
    base_beats = b0;
    const_crc = 1'b1;
    mr_mode = 0;
    sent.delete();
    sent.push_back({1'b1, 64'h0123456789ABCDEF});
    src_q = sent;
    pump(50, -1);
    const_crc = 1'b0;
    exp_fc = (exp_fc + 1) % 4;
    n_chk++;
    if (beats.size() - b0 != 2) begin
      n_fail++;
      $display("FAIL single_count: got %0d beats required 2", beats.size() - b0);
    end
    got = (beats.size() > b0) ? beats[b0] : 'x;
    n_chk++;
    if (got !== {1'b0, 64'h0123456789ABCDEF}) begin
      n_fail++;
      $display("FAIL single_beat0: got %h required %h", got, {1'b0, 64'h0123456789ABCDEF});
    end
    got = (beats.size() > b0 + 1) ? beats[b0+1] : 'x;
    n_chk++;
    if (got !== {1'b1, 64'h00000000EDCBA987}) begin
      n_fail++;
      $display("FAIL single_trailer: got %h required %h", got, {1'b1, 64'h00000000EDCBA987});
    end
    cc = (clr_cyc.size() == c0 + 1) ? clr_cyc[c0] : -100;
    dc = (dv_cyc.size() > d0) ? dv_cyc[d0] : -200;
    n_chk++;
    if (cc != dc - 1) begin
      n_fail++;
      $display("FAIL single_clr_timing: got clr cycle %0d accept cycle %0d, required one apart", cc, dc);
    end
    n_chk++;
    if (frame_cnt !== CNTB'(exp_fc)) begin
      n_fail++;
      $display("FAIL single_frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_four_word();
    int b0, d0, span, gap;
    logic [64:0] got;
    logic [63:0] cw;
    b0 = beats.size(); d0 = dv_cyc.size();
    base_beats = b0;
    mr_mode = 0;
    sent.delete();
    add_frame(4, 1'b1);
    build_expected();
    src_q = sent;
    pump(60, -1);
    exp_fc = (exp_fc + exp_nfr) % 4;
    n_chk++;
    if (dv_cyc.size() - d0 != 4) begin
      n_fail++;
      $display("FAIL four_dv_count: got %0d required 4", dv_cyc.size() - d0);
    end
    span = (dv_cyc.size() >= d0 + 4) ? dv_cyc[d0+3] - dv_cyc[d0] : -1;
    n_chk++;
    if (span != 3) begin
      n_fail++;
      $display("FAIL four_dv_consecutive: got span %0d required 3", span);
    end
    for (int i = 0; i < 4; i++) begin
      cw = (crc_words.size() > d0 + i) ? crc_words[d0+i] : 'x;
      n_chk++;
      if (cw !== sent[i][63:0]) begin
        n_fail++;
        $display("FAIL four_crc_data %0d: got %h required %h", i, cw, sent[i][63:0]);
      end
    end
    n_chk++;
    if (beats.size() - b0 != 5) begin
      n_fail++;
      $display("FAIL four_beat_count: got %0d required 5", beats.size() - b0);
    end
    foreach (exp_q[i]) begin
      got = (beats.size() > b0 + i) ? beats[b0+i] : 'x;
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL four_beat %0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    gap = (beat_cyc.size() >= b0 + 5) ? beat_cyc[b0+4] - beat_cyc[b0+3] : -1;
    n_chk++;
    if (gap != 1) begin
      n_fail++;
      $display("FAIL four_trailer_gap: got %0d cycles required 1", gap);
    end
  endtask

  task automatic test_backpressure();
    int b0, d0, v0;
    logic [64:0] got;
    b0 = beats.size(); d0 = dv_cyc.size(); v0 = stall_viol;
    base_beats = b0;
    mr_mode = 2;
    sent.delete();
    add_frame(4, 1'b1);
    build_expected();
    src_q = sent;
    pump(80, -1);
    mr_mode = 0;
    exp_fc = (exp_fc + exp_nfr) % 4;
    n_chk++;
    if (beats.size() - b0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d required %0d", beats.size() - b0, exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (beats.size() > b0 + i) ? beats[b0+i] : 'x;
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat %0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    n_chk++;
    if (dv_cyc.size() - d0 != 4) begin
      n_fail++;
      $display("FAIL bp_dv_count: got %0d required 4", dv_cyc.size() - d0);
    end
    n_chk++;
    if (stall_viol - v0 != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable stall cycles required 0", stall_viol - v0);
    end
    n_chk++;
    if (frame_cnt !== CNTB'(exp_fc)) begin
      n_fail++;
      $display("FAIL bp_frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_forced_close();
    int b0, e0;
    logic [64:0] got;
    b0 = beats.size(); e0 = err_n;
    base_beats = b0;
    mr_mode = 0;
    sent.delete();
    add_frame(5, 1'b0);
    add_frame(1, 1'b1);
    build_expected();
    src_q = sent;
    pump(80, -1);
    exp_fc = (exp_fc + exp_nfr) % 4;
    n_chk++;
    if (err_n - e0 != 1) begin
      n_fail++;
      $display("FAIL forced_err_len: got %0d pulses required 1", err_n - e0);
    end
    n_chk++;
    if (beats.size() - b0 != 8) begin
      n_fail++;
      $display("FAIL forced_beat_count: got %0d required 8", beats.size() - b0);
    end
    foreach (exp_q[i]) begin
      got = (beats.size() > b0 + i) ? beats[b0+i] : 'x;
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL forced_beat %0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    n_chk++;
    if (frame_cnt !== CNTB'(exp_fc)) begin
      n_fail++;
      $display("FAIL forced_frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    logic [64:0] got;
    mr_mode = 0;
    base_beats = beats.size();
    sent.delete();
    add_frame(4, 1'b1);
    src_q = sent;
    pump(40, 2);
    rst = 1'b1;
    #1;
    exp_fc = 0;
    n_chk++;
    if ({m_valid, s_ready, crc_data_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b required 000", {m_valid, s_ready, crc_data_valid});
    end
    n_chk++;
    if (frame_cnt !== '0) begin
      n_fail++;
      $display("FAIL rstmid_frame_cnt: got %0d required 0", frame_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_q.delete();
    b0 = beats.size();
    base_beats = b0;
    sent.delete();
    add_frame(3, 1'b1);
    build_expected();
    src_q = sent;
    pump(60, -1);
    exp_fc = (exp_fc + exp_nfr) % 4;
    n_chk++;
    if (beats.size() - b0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_beat_count: got %0d required %0d", beats.size() - b0, exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (beats.size() > b0 + i) ? beats[b0+i] : 'x;
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_beat %0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    n_chk++;
    if (frame_cnt !== CNTB'(exp_fc)) begin
      n_fail++;
      $display("FAIL rstmid_frame_cnt_after: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_cnt_wrap();
    int b0, e0;
    logic [64:0] got;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fc = 0;
    b0 = beats.size(); e0 = err_n;
    base_beats = b0;
    mr_mode = 1;
    sent.delete();
    for (int f = 0; f < 5; f++) add_frame($urandom_range(1, 4), 1'b1);
    build_expected();
    src_q = sent;
    pump(600, -1);
    mr_mode = 0;
    exp_fc = (exp_fc + exp_nfr) % 4;
    foreach (exp_q[i]) begin
      got = (beats.size() > b0 + i) ? beats[b0+i] : 'x;
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_beat %0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    n_chk++;
    if (err_n - e0 != 0) begin
      n_fail++;
      $display("FAIL wrap_err_len: got %0d pulses required 0", err_n - e0);
    end
    n_chk++;
    if (frame_cnt !== CNTB'(exp_fc)) begin
      n_fail++;
      $display("FAIL wrap_frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_random();
    int b0, d0, e0;
    logic [64:0] got;
    b0 = beats.size(); d0 = dv_cyc.size(); e0 = err_n;
    base_beats = b0;
    mr_mode = 1;
    sent.delete();
    for (int i = 0; i < 14; i++)
      sent.push_back({(i == 13) || ($urandom_range(0, 2) == 0), $urandom(), $urandom()});
    build_expected();
    src_q = sent;
    pump(1000, -1);
    mr_mode = 0;
    exp_fc = (exp_fc + exp_nfr) % 4;
    n_chk++;
    if (beats.size() - b0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_beat_count: got %0d required %0d", beats.size() - b0, exp_q.size());
    end
    foreach (exp_q[i]) begin
      got = (beats.size() > b0 + i) ? beats[b0+i] : 'x;
      n_chk++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_beat %0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    n_chk++;
    if (dv_cyc.size() - d0 != sent.size()) begin
      n_fail++;
      $display("FAIL rand_dv_count: got %0d required %0d", dv_cyc.size() - d0, sent.size());
    end
    n_chk++;
    if (err_n - e0 != exp_err) begin
      n_fail++;
      $display("FAIL rand_err_len: got %0d pulses required %0d", err_n - e0, exp_err);
    end
    n_chk++;
    if (frame_cnt !== CNTB'(exp_fc)) begin
      n_fail++;
      $display("FAIL rand_frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_four_word();
    test_backpressure();
    test_forced_close();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
- Upstream framer for the 64-bit CRC-32 engine.
- Accepts a 64-bit payload stream, forwards each payload word downstream, and feeds the same words to the CRC engine.
- After the last payload word it appends one 64-bit trailer word carrying the final CRC.
- Sits between the link-layer packet source and the serializer on the transmit path.

Parameters:
- DATA_BITS, 64, payload/output word width; must equal the CRC engine data width.
- CRC_BITS, 32, CRC width; must equal the CRC engine CRC width.
- MAX_WORDS, 256, maximum payload words per frame before a forced close.
- FINAL_XOR, 32'hFFFFFFFF, value XORed onto crc_in to form the transmitted FCS.
- CNT_BITS, 16, width of frame_cnt.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_data  in  DATA_BITS  payload word
- s_valid  in  1  payload word valid
- s_last  in  1  marks last payload word of frame
- s_ready  out  1  framer accepts the payload word
- m_data  out  DATA_BITS  output word (payload or trailer)
- m_valid  out  1  output word valid
- m_last  out  1  high on the trailer word only
- m_ready  in  1  downstream accepts the output word
- crc_clr  out  1  CRC engine clear; integration ORs it with rst into the engine reset
- crc_data  out  DATA_BITS  word to the CRC engine
- crc_data_valid  out  1  CRC engine update enable
- crc_in  in  CRC_BITS  CRC engine register output
- frame_cnt  out  CNT_BITS  frames completed
- err_len  out  1  one-cycle pulse on a forced close at MAX_WORDS

Behaviour:
- Decided: one clock clk; rst is asynchronous and active-high.
- Reset values: state=IDLE, m_valid=0, m_last=0, m_data=0, frame_cnt=0, word counter=0, err_len=0.
- The combinational outputs s_ready, crc_clr and crc_data_valid are therefore 0 during reset.
- Output stage: single register (m_data/m_valid/m_last).
  - free = !m_valid || m_ready.
  - m_valid clears on a handshake when nothing new is loaded.
  - m_data/m_last hold while m_valid && !m_ready.
- IDLE:
  - s_ready=0.
  - On s_valid, go to CLEAR; the word is not consumed.
- CLEAR (exactly 1 cycle):
  - crc_clr=1, so the engine loads all-ones at the next edge.
  - Clear the word counter; go to PASS.
- PASS:
  - s_ready = free.
  - On s_valid && s_ready: m_data<=s_data, m_valid<=1, m_last<=0, counter++.
  - In the same cycle, crc_data=s_data and crc_data_valid=1 (combinational, gated by the handshake).
  - If s_last, or counter == MAX_WORDS-1 at accept, go to TRAILER.
  - In the forced case (no s_last), pulse err_len.
  - After a forced close, the remaining words of the source frame start a new frame.
- TRAILER:
  - s_ready=0 and crc_data_valid=0.
  - crc_in already reflects the last word here, because the engine has one-cycle latency.
  - When free: m_data <= {(DATA_BITS-CRC_BITS)'b0, crc_in ^ FINAL_XOR}, m_valid<=1, m_last<=1; go to IDLE.
- frame_cnt increments on m_valid && m_ready && m_last and wraps modulo 2^CNT_BITS.
- Back-to-back frames: IDLE → CLEAR costs 2 dead input cycles per frame.
- Throughput: 1 word/cycle inside a frame when m_ready is held high.
- Backpressure: m_ready low in PASS stalls s_ready with no CRC update. m_ready low in TRAILER holds the trailer and keeps state TRAILER.
- Reset mid-frame: the frame is discarded, outputs return to reset values immediately, and the next frame restarts from IDLE/CLEAR.
- s_last is sampled only on a handshake; s_last outside PASS has no effect.

Decomposition:
- Shared package: state encoding (IDLE, CLEAR, PASS, TRAILER), FINAL_XOR default, DATA_BITS/CRC_BITS defaults.
- One natural sub-module: crc_frame_out_reg, the single-entry output register with the valid/ready hold rule.
- The CRC engine stays external.

Test Plan:
- Single-word frame: s_data=64'h0123456789ABCDEF with s_last, stub crc_in=32'h12345678 → output beat 1 = 64'h0123456789ABCDEF, m_last=0; beat 2 = 64'h00000000EDCBA987, m_last=1; crc_clr pulses 1 cycle before the accept; frame_cnt=1.
- Four-word frame with m_ready=1 → crc_data_valid high for exactly 4 consecutive cycles; trailer follows on the next cycle; total 5 output beats.
- m_ready low for 3 cycles during payload word 2 and during the trailer → no duplicates or drops, crc_data_valid count = 4, m_data stable while stalled.
- MAX_WORDS=4, stream 6 words without s_last → frame of 4 words + trailer, err_len pulses once, next frame has 2 words + trailer, frame_cnt=2.
- Assert rst for 1 cycle during payload word 3 → m_valid=0 at once, frame_cnt=0, next frame is framed correctly from CLEAR.
- frame_cnt with CNT_BITS=2 after 5 frames → reads 1.
